// File: rtl/snoop_bus_arbiter_if.sv
// Bus-side signal bundle for snoop_bus_arbiter.
// The master modport is the arbiter's view; the slave modport is the CPU-side view.
interface snoop_bus_arbiter_if #(
    parameter int unsigned WIDTH = 10
) ();

    logic [2:0]       req;
    logic [WIDTH-1:0] msg0;
    logic [WIDTH-1:0] msg1;
    logic [WIDTH-1:0] msg2;
    logic [2:0]       snoop_shared;
    logic [2:0]       grant;
    logic [WIDTH-1:0] bus;
    logic             bus_valid;
    logic             shared_out;
    logic             done;

    modport master (
        input  req,
        input  msg0,
        input  msg1,
        input  msg2,
        input  snoop_shared,
        output grant,
        output bus,
        output bus_valid,
        output shared_out,
        output done
    );

    modport slave (
        output req,
        output msg0,
        output msg1,
        output msg2,
        output snoop_shared,
        input  grant,
        input  bus,
        input  bus_valid,
        input  shared_out,
        input  done
    );

endinterface

// File: rtl/snoop_bus_arbiter.sv
// 3-requester round-robin snoop bus arbiter.
// A granted CPU's message is latched and broadcast for HOLD_CYCLES cycles. The non-owner
// snoop_shared bits are then ORed and returned to the owner together with a one-cycle done pulse.
// Optional macro BUS_ARB_COUNT_EN adds a 16-bit wrapping count of completed transactions.
module snoop_bus_arbiter #(
    parameter int unsigned WIDTH       = 10,
    // Legal range 1..15; the hold counter is 4 bits wide.
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                clock,
    input  logic                clear,
    snoop_bus_arbiter_if.master bus_if
`ifdef BUS_ARB_COUNT_EN
    ,
    output logic [15:0]         txn_count
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StBcast,
        StCollect,
        StDone
    } state_e;

    localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [2:0]       grant_q, grant_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             bus_valid_q, bus_valid_d;
    logic             shared_q, shared_d;
    logic             done_q, done_d;

    logic [1:0]       win_idx;
    logic [WIDTH-1:0] win_msg;

`ifdef BUS_ARB_COUNT_EN
    logic [15:0]      txn_count_q, txn_count_d;
`endif

    // Round-robin pick: scan upward starting just after the last owner.
    always_comb begin
        win_idx = 2'd0;
        unique case (ptr_q)
            2'd0: begin
                if (bus_if.req[1])      win_idx = 2'd1;
                else if (bus_if.req[2]) win_idx = 2'd2;
                else                    win_idx = 2'd0;
            end
            2'd1: begin
                if (bus_if.req[2])      win_idx = 2'd2;
                else if (bus_if.req[0]) win_idx = 2'd0;
                else                    win_idx = 2'd1;
            end
            default: begin
                if (bus_if.req[0])      win_idx = 2'd0;
                else if (bus_if.req[1]) win_idx = 2'd1;
                else                    win_idx = 2'd2;
            end
        endcase
    end

    // Message of the selected requester, latched only at grant.
    always_comb begin
        win_msg = bus_if.msg0;
        unique case (win_idx)
            2'd1:    win_msg = bus_if.msg1;
            2'd2:    win_msg = bus_if.msg2;
            default: win_msg = bus_if.msg0;
        endcase
    end

    // Next state and next registered outputs of the transaction FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        bus_d       = bus_q;
        bus_valid_d = bus_valid_q;
        shared_d    = shared_q;
        done_d      = done_q;

        unique case (state_q)
            StIdle: begin
                if (bus_if.req != 3'b000) begin
                    owner_d     = win_idx;
                    grant_d     = 3'b001 << win_idx;
                    bus_d       = win_msg;
                    bus_valid_d = 1'b1;
                    cnt_d       = 4'd1;
                    state_d     = StBcast;
                end
            end
            StBcast: begin
                if (cnt_q == HoldLast) begin
                    bus_valid_d = 1'b0;
                    bus_d       = '0;
                    state_d     = StCollect;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCollect: begin
                // The owner's own snoop response is masked off.
                shared_d = |(bus_if.snoop_shared & ~grant_q);
                done_d   = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                grant_d  = 3'b000;
                done_d   = 1'b0;
                shared_d = 1'b0;
                cnt_d    = 4'd0;
                ptr_d    = owner_q;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef BUS_ARB_COUNT_EN
    // Completed-transaction counter; wraps naturally at 16 bits.
    always_comb begin
        txn_count_d = txn_count_q + 16'(done_q);
    end
`endif

    // State register with synchronous active-high clear; clear aborts any transaction.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            ptr_q       <= 2'd2;
            owner_q     <= 2'd0;
            grant_q     <= 3'b000;
            bus_q       <= '0;
            bus_valid_q <= 1'b0;
            shared_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            bus_q       <= bus_d;
            bus_valid_q <= bus_valid_d;
            shared_q    <= shared_d;
            done_q      <= done_d;
        end
    end

`ifdef BUS_ARB_COUNT_EN
    // Counter register, cleared with the rest of the block.
    always_ff @(posedge clock) begin
        if (clear) begin
            txn_count_q <= 16'h0000;
        end else begin
            txn_count_q <= txn_count_d;
        end
    end

    assign txn_count = txn_count_q;
`endif

    assign bus_if.grant      = grant_q;
    assign bus_if.bus        = bus_q;
    assign bus_if.bus_valid  = bus_valid_q;
    assign bus_if.shared_out = shared_q;
    assign bus_if.done       = done_q;

endmodule
